// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Circular store buffer between the MEM stage and data memory.
//               Stores are queued and drained one per cycle whenever there is
//               no load using the memory port. Loads forward from the youngest
//               matching queued store; otherwise they see the memory read data.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic                       cpu_re,
  input  logic [31:0]                cpu_addr,
  input  logic [31:0]                cpu_wdata,
  input  logic [31:0]                cpu_pc,
  output logic [31:0]                cpu_rdata,
  output logic                       stall,
  output logic                       dm_we,
  output logic [31:0]                dm_addr,
  output logic [31:0]                dm_wdata,
  output logic [31:0]                dm_pc,
  input  logic [31:0]                dm_rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Entry storage; validity is implied by position relative to head/count.
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full;
  logic             is_empty;
  logic             drain;
  logic             push;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] fwd_idx;

  assign is_empty = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  // Loads own the single memory address, so draining waits while cpu_re is up.
  assign drain    = !is_empty && !cpu_re && !reset;
  assign stall    = cpu_we && full && !drain && !reset;
  assign push     = cpu_we && !stall && !reset;

  assign empty    = is_empty || reset;
  assign count    = count_q;

  // Memory port: drain the head entry, otherwise present the load address.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = cpu_addr;
    dm_wdata = 32'd0;
    dm_pc    = 32'd0;
    if (drain) begin
      dm_we    = 1'b1;
      dm_addr  = {addr_q[head_q], 2'b00};
      dm_wdata = data_q[head_q];
      dm_pc    = pc_q[head_q];
    end
  end

  // Forwarding scan from oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (addr_q[fwd_idx] == cpu_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
    cpu_rdata = fwd_hit ? fwd_data : dm_rdata;
  end

  // Pointer and occupancy next-state; push and pop may coincide.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + PTR_W'(1);
    if (push)  tail_d = tail_q + PTR_W'(1);
    if (push && !drain)      count_d = count_q + (PTR_W+1)'(1);
    else if (!push && drain) count_d = count_q - (PTR_W+1)'(1);
  end

  // Pointer/occupancy registers; reset discards all pending stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload write at the tail; contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr[31:2];
      data_q[tail_q] <= cpu_wdata;
      pc_q[tail_q]   <= cpu_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_addr, cpu_wdata, cpu_pc, cpu_rdata;
  logic        stall, dm_we, empty;
  logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;
  ent_t q[$];

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc), .cpu_rdata(cpu_rdata),
    .stall(stall), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One normal cycle: drive, check combinational outputs against the model,
  // clock, then advance the model.
  task automatic step(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] pc,
                      input logic [31:0] dmr);
    logic        e_drain, e_stall;
    logic [31:0] e_rdata;
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = wd; cpu_pc = pc;
    dm_rdata = dmr;
    #1;
    e_drain = (q.size() != 0) && !re;
    e_stall = we && (q.size() == 4) && !e_drain;
    e_rdata = dmr;
    foreach (q[i]) if (q[i].a == a[31:2]) e_rdata = q[i].d;
    chk("count",  32'(count), 32'(q.size()));
    chk("empty",  32'(empty), 32'(q.size() == 0));
    chk("stall",  32'(stall), 32'(e_stall));
    chk("dm_we",  32'(dm_we), 32'(e_drain));
    chk("dm_addr",  dm_addr,  e_drain ? {q[0].a, 2'b00} : a);
    chk("dm_wdata", dm_wdata, e_drain ? q[0].d : 32'd0);
    chk("dm_pc",    dm_pc,    e_drain ? q[0].p : 32'd0);
    if (re) chk("cpu_rdata", cpu_rdata, e_rdata);
    @(posedge clk);
    if (e_drain) void'(q.pop_front());
    if (we && !e_stall) q.push_back('{a: a[31:2], d: wd, p: pc});
    #1;
  endtask

  // One reset cycle with arbitrary request activity that must be ignored.
  task automatic rst_step(input logic we, input logic re, input logic [31:0] a);
    reset = 1'b1;
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = 32'h1234_5678; cpu_pc = 32'h9;
    #1;
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    @(posedge clk);
    q.delete();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic        we, re;
    logic [31:0] a;
    reset = 1'b1; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
    cpu_pc = 0; dm_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single store, then idle while it drains.
    step(1, 0, 32'h10, 32'h1122_3344, 32'h3000, 0);
    chk("single_count", 32'(count), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("single_empty", 32'(empty), 32'd1);

    // Forwarding: youngest of two same-address stores wins.
    step(1, 1, 32'h20, 32'hAAAA_0001, 32'h100, 32'h0);
    step(1, 1, 32'h20, 32'hAAAA_0002, 32'h104, 32'h0);
    step(0, 1, 32'h22, 0, 0, 32'h5555_5555);
    chk("fwd_rdata", cpu_rdata, 32'hAAAA_0002);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Load miss on an empty buffer.
    step(0, 1, 32'h40, 0, 0, 32'hDEAD_BEEF);
    chk("miss_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("miss_addr",  dm_addr,  32'h40);

    // Full stall, then release with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1, 1, 32'(i * 4), 32'(32'hB0 + i), 32'(32'h200 + i * 4), 0);
    step(1, 1, 32'h10, 32'hB4, 32'h210, 0);
    chk("full_count", 32'(count), 32'd4);
    step(1, 0, 32'h10, 32'hB4, 32'h210, 0);
    chk("full_keep4", 32'(count), 32'd4);
    repeat (5) step(0, 0, 0, 0, 0, 0);

    // Wrap-around: ten stores with idles in between.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 32'(32'h100 + i * 4), 32'(32'hC000 + i), 32'(32'h4000 + i * 4), 0);
      if (i % 3 == 2) step(0, 0, 0, 0, 0, 0);
    end
    repeat (5) step(0, 0, 0, 0, 0, 0);

    // Reset with three entries pending discards them.
    for (int i = 0; i < 3; i++) step(1, 1, 32'(32'h80 + i * 4), 32'(32'hD0 + i), 32'h500, 0);
    rst_step(1, 0, 32'h80);
    step(0, 1, 32'h84, 0, 0, 32'h0BAD_F00D);
    chk("post_rst_rdata", cpu_rdata, 32'h0BAD_F00D);
    chk("post_rst_count", 32'(count), 32'd0);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_step(1'($urandom), 1'($urandom), 32'($urandom_range(0, 7) * 4));
      end else begin
        we = ($urandom_range(0, 99) < 55);
        re = ($urandom_range(0, 99) < 45);
        a  = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        step(we, re, a, $urandom, $urandom, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port cpu_we  in  1  MEM-stage store request (word store).
REQ-005 SHALL have port cpu_re  in  1  MEM-stage load request.
REQ-006 SHALL have port cpu_addr  in  32  byte address of the load/store; bits [1:0] ignored.
REQ-007 SHALL have port cpu_wdata  in  32  store data.
REQ-008 SHALL have port cpu_pc  in  32  PC of the MEM-stage instruction.
REQ-009 SHALL have port cpu_rdata  out  32  load data returned to the pipeline.
REQ-010 SHALL have port stall  out  1  freeze the pipeline; the store is not accepted this cycle.
REQ-011 SHALL have port dm_we  out  1  data memory write enable.
REQ-012 SHALL have port dm_addr  out  32  data memory address, shared by reads and drains.
REQ-013 SHALL have port dm_wdata  out  32  data memory write data.
REQ-014 SHALL have port dm_pc  out  32  PC of the draining store, for the memory's write trace.
REQ-015 SHALL have port dm_rdata  in  32  data memory combinational read data.
REQ-016 SHALL have port empty  out  1  high when there are no valid entries.
REQ-017 SHALL have port count  out  clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 SHALL hold stores in a circular FIFO of DEPTH entries {addr[31:2], wdata, pc}, with head/tail pointers that wrap modulo DEPTH.
REQ-019 Drain condition SHALL be drain = !empty & !cpu_re & !reset; the memory port has one address, so loads take priority.
REQ-020 When drain is high, the block SHALL drive dm_we=1, dm_addr={head.addr,2'b00}, dm_wdata=head.wdata and dm_pc=head.pc, and SHALL pop the head at the clock edge.
REQ-021 When drain is low, the block SHALL drive dm_we=0, dm_addr=cpu_addr, dm_wdata=0 and dm_pc=0.
REQ-022 Push condition SHALL be push = cpu_we & !stall; the entry is written at the tail at the clock edge.
REQ-023 The block SHALL set stall = cpu_we & full & !drain, which reduces to cpu_we & full & cpu_re.
REQ-024 Push and pop in the same cycle SHALL both take effect: count is unchanged, and this is legal when full.
REQ-025 Load forwarding SHALL be combinational: cpu_addr[31:2] is compared against all valid entries, and the youngest match supplies cpu_rdata.
REQ-026 When no entry matches, cpu_rdata SHALL equal dm_rdata.
REQ-027 A store pushed in cycle N SHALL NOT forward to a load in cycle N; it SHALL forward from cycle N+1 onward, until drained.
REQ-028 If cpu_we and cpu_re are both high, the load SHALL be serviced per REQ-025/026 against the pre-push contents, and the store SHALL be pushed (subject to stall).
REQ-029 Multiple entries with the same address SHALL all be kept and drained in program order; there is no merging.
REQ-030 The block SHALL drain at most one entry per cycle and accept at most one push per cycle.
REQ-031 When cpu_re is held high continuously, the block SHALL drain nothing; stores continue to be accepted until full.

Reset
REQ-032 On reset, the block SHALL clear head, tail and count to 0 and invalidate all entries, so pending stores are discarded without being written.
REQ-033 During reset, the block SHALL drive dm_we=0, stall=0 and empty=1.
REQ-034 Reset SHALL override any push or pop in the same cycle.

Verification
REQ-035 Scenario "single store": store 0x11223344 to 0x10 at PC 0x3000, then idle -> count=1 next cycle; the following cycle has dm_we=1, dm_addr=0x10, dm_pc=0x3000; then empty=1.
REQ-036 Scenario "forwarding": store 0xAAAA0001 then 0xAAAA0002 to 0x20 with cpu_re held high, then a load from 0x22 -> cpu_rdata=0xAAAA0002; no dm_we while cpu_re is high.
REQ-037 Scenario "full stall": cpu_re high, 5 stores to 0x0, 0x4, 0x8, 0xC, 0x10 -> 5th store sees stall=1 with count=4; drop cpu_re -> 5th store accepted in the same cycle the 0x0 entry drains, with count staying 4.
REQ-038 Scenario "wrap-around": 10 stores with interleaved idles (DEPTH=4) -> DM receives all 10 writes in order with the correct addr/data/pc; count never exceeds 4.
REQ-039 Scenario "load miss": empty buffer, dm_rdata=0xDEADBEEF, load from 0x40 -> cpu_rdata=0xDEADBEEF and dm_addr=0x40.
REQ-040 Scenario "reset mid-operation": 3 entries pending, assert reset for 1 cycle -> no dm_we during or after reset; count=0; a subsequent load from a previously stored address returns dm_rdata.
